// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: initial value, round constant, FSM states, state layout.
package ascon_pkg;

    localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD_PERM,
        S_DSEP,
        S_PT_WAIT,
        S_CT_OUT,
        S_PT_PERM,
        S_FIN,
        S_TAG_OUT
    } fsm_t;

    // x0 occupies the most significant 64 bits.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } state_t;

    // Round constant for round index i, placed in the low byte of x2.
    function automatic logic [63:0] rc(input logic [3:0] i);
        return {56'h0, 4'hf - i, i};
    endfunction

    // 64-bit rotate right by a fixed amount.
    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_aead_sequencer_if.sv
// Stream and control bundle between the ASCON sequencer and its user.
//
// Handshakes: a block moves on a rising edge where valid and ready are both
// high. Ready outputs depend only on the engine state, never on valid. Once
// ct_valid or tag_valid is raised it stays high with stable data until the
// corresponding ready is seen.
interface ascon_aead_sequencer_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         ad_none;
    logic [63:0]  ad_data;
    logic         ad_valid;
    logic         ad_ready;
    logic         ad_last;
    logic [63:0]  pt_data;
    logic         pt_valid;
    logic         pt_ready;
    logic         pt_last;
    logic [63:0]  ct_data;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] tag;
    logic         tag_valid;
    logic         tag_ready;
    logic         busy;

    modport master (
        output start, key, nonce, ad_none,
        output ad_data, ad_valid, ad_last,
        output pt_data, pt_valid, pt_last,
        output ct_ready, tag_ready,
        input  ad_ready, pt_ready, ct_data, ct_valid, tag, tag_valid, busy
    );

    modport slave (
        input  start, key, nonce, ad_none,
        input  ad_data, ad_valid, ad_last,
        input  pt_data, pt_valid, pt_last,
        input  ct_ready, tag_ready,
        output ad_ready, pt_ready, ct_data, ct_valid, tag, tag_valid, busy
    );
endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant add, S-box layer, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  state_t      s_in,
    input  logic [3:0]  rnd,
    output state_t      s_out
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;

    // Bitsliced S-box over the 64 columns followed by per-word diffusion.
    always_comb begin
        a0 = s_in.x0 ^ s_in.x4;
        a2 = s_in.x2 ^ rc(rnd) ^ s_in.x1;
        a4 = s_in.x4 ^ s_in.x3;
        a1 = s_in.x1;
        a3 = s_in.x3;

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;

        b1 = b1 ^ b0;
        b0 = b0 ^ b4;
        b3 = b3 ^ b2;
        b2 = ~b2;

        s_out.x0 = b0 ^ ror(b0, 19) ^ ror(b0, 28);
        s_out.x1 = b1 ^ ror(b1, 61) ^ ror(b1, 39);
        s_out.x2 = b2 ^ ror(b2, 1)  ^ ror(b2, 6);
        s_out.x3 = b3 ^ ror(b3, 10) ^ ror(b3, 17);
        s_out.x4 = b4 ^ ror(b4, 7)  ^ ror(b4, 41);
    end

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Iterative ASCON-128 encryption engine: one permutation round per clock,
// sequenced through init, associated data, plaintext and finalization.
module ascon_aead_sequencer
    import ascon_pkg::*;
#(
    parameter int          PA_ROUNDS = 12,
    parameter int          PB_ROUNDS = 6,
    parameter logic [63:0] IV        = ASCON_IV
) (
    input  logic                     clk,
    input  logic                     rst,
    ascon_aead_sequencer_if.slave    io,
    output fsm_t                     dbg_state
);

    // p^a runs rounds 0..LAST, p^b runs the tail FIRST_B..LAST.
    localparam logic [3:0] RND_LAST    = 4'(PA_ROUNDS - 1);
    localparam logic [3:0] RND_FIRST_B = 4'(PA_ROUNDS - PB_ROUNDS);

    fsm_t          fsm_q, fsm_d;
    state_t        st_q, st_d, rnd_out;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  key_q, key_d;
    logic          ad_none_q, ad_none_d;
    logic          last_q, last_d;
    logic [63:0]   ct_q, ct_d;
    logic [127:0]  tag_q, tag_d;

    ascon_round u_round (
        .s_in  (st_q),
        .rnd   (rnd_q),
        .s_out (rnd_out)
    );

    // Handshake outputs are pure decodes of the state register.
    assign io.ad_ready  = (fsm_q == S_AD_WAIT);
    assign io.pt_ready  = (fsm_q == S_PT_WAIT);
    assign io.ct_valid  = (fsm_q == S_CT_OUT);
    assign io.tag_valid = (fsm_q == S_TAG_OUT);
    assign io.busy      = (fsm_q != S_IDLE);
    assign io.ct_data   = ct_q;
    assign io.tag       = tag_q;
    assign dbg_state    = fsm_q;

    // State, counter and output registers; reset aborts any message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            st_q      <= '0;
            rnd_q     <= '0;
            key_q     <= '0;
            ad_none_q <= 1'b0;
            last_q    <= 1'b0;
            ct_q      <= '0;
            tag_q     <= '0;
        end else begin
            fsm_q     <= fsm_d;
            st_q      <= st_d;
            rnd_q     <= rnd_d;
            key_q     <= key_d;
            ad_none_q <= ad_none_d;
            last_q    <= last_d;
            ct_q      <= ct_d;
            tag_q     <= tag_d;
        end
    end

    // Next-state logic: phase sequencing, absorb XORs and key injection.
    always_comb begin
        fsm_d     = fsm_q;
        st_d      = st_q;
        rnd_d     = rnd_q;
        key_d     = key_q;
        ad_none_d = ad_none_q;
        last_d    = last_q;
        ct_d      = ct_q;
        tag_d     = tag_q;

        unique case (fsm_q)
            S_IDLE: begin
                if (io.start) begin
                    st_d      = {IV, io.key, io.nonce};
                    key_d     = io.key;
                    ad_none_d = io.ad_none;
                    rnd_d     = 4'd0;
                    fsm_d     = S_INIT;
                end
            end
            S_INIT: begin
                st_d  = rnd_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) begin
                    st_d.x3 = rnd_out.x3 ^ key_q[127:64];
                    st_d.x4 = rnd_out.x4 ^ key_q[63:0];
                    fsm_d   = ad_none_q ? S_DSEP : S_AD_WAIT;
                end
            end
            S_AD_WAIT: begin
                if (io.ad_valid) begin
                    st_d.x0 = st_q.x0 ^ io.ad_data;
                    last_d  = io.ad_last;
                    rnd_d   = RND_FIRST_B;
                    fsm_d   = S_AD_PERM;
                end
            end
            S_AD_PERM: begin
                st_d  = rnd_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) begin
                    fsm_d = last_q ? S_DSEP : S_AD_WAIT;
                end
            end
            S_DSEP: begin
                st_d.x4 = st_q.x4 ^ 64'h1;
                fsm_d   = S_PT_WAIT;
            end
            S_PT_WAIT: begin
                if (io.pt_valid) begin
                    st_d.x0 = st_q.x0 ^ io.pt_data;
                    ct_d    = st_q.x0 ^ io.pt_data;
                    last_d  = io.pt_last;
                    fsm_d   = S_CT_OUT;
                end
            end
            S_CT_OUT: begin
                if (io.ct_ready) begin
                    if (last_q) begin
                        st_d.x1 = st_q.x1 ^ key_q[127:64];
                        st_d.x2 = st_q.x2 ^ key_q[63:0];
                        rnd_d   = 4'd0;
                        fsm_d   = S_FIN;
                    end else begin
                        rnd_d = RND_FIRST_B;
                        fsm_d = S_PT_PERM;
                    end
                end
            end
            S_PT_PERM: begin
                st_d  = rnd_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) begin
                    fsm_d = S_PT_WAIT;
                end
            end
            S_FIN: begin
                st_d  = rnd_out;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) begin
                    tag_d = {rnd_out.x3 ^ key_q[127:64], rnd_out.x4 ^ key_q[63:0]};
                    fsm_d = S_TAG_OUT;
                end
            end
            S_TAG_OUT: begin
                if (io.tag_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

endmodule
